// File: rtl/tcb_pkg.sv
// Shared TCB types: interface modes, byte order, and the state type of the
// memory-to-reference converter.
package tcb_pkg;

  typedef enum logic {
    TCB_MEMORY    = 1'b0,
    TCB_REFERENCE = 1'b1
  } tcb_mode_t;

  typedef enum logic {
    TCB_DESCENDING = 1'b0,
    TCB_ASCENDING  = 1'b1
  } tcb_order_t;

  typedef enum logic {
    M2R_IDLE = 1'b0,
    M2R_BUSY = 1'b1
  } tcb_m2r_state_t;

  // Width of the log2 transfer size field for a given data width.
  function automatic int unsigned tcb_siz_w(input int unsigned dat);
    int unsigned w;
    w = $clog2($clog2(dat / 8) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tcb_if.sv
// TCB interface with flat request/response signals and PHY parameters.
interface tcb_if
  import tcb_pkg::*;
#(
  parameter tcb_mode_t   MOD = TCB_MEMORY,
  parameter tcb_order_t  ORD = TCB_DESCENDING,
  parameter int unsigned DLY = 0,
  parameter int unsigned DAT = 32,
  parameter int unsigned ADR = 32
);

  localparam int unsigned BEN = DAT / 8;
  localparam int unsigned SIZ = tcb_siz_w(DAT);

  logic           vld;
  logic           rdy;
  logic           req_cmd;
  logic           req_wen;
  logic           req_ndn;
  logic [ADR-1:0] req_adr;
  logic [SIZ-1:0] req_siz;
  logic [BEN-1:0] req_ben;
  logic [DAT-1:0] req_wdt;
  logic [DAT-1:0] rsp_rdt;
  logic           rsp_sts;

  modport man (
    output vld, req_cmd, req_wen, req_ndn, req_adr, req_siz, req_ben, req_wdt,
    input  rdy, rsp_rdt, rsp_sts
  );

  modport sub (
    input  vld, req_cmd, req_wen, req_ndn, req_adr, req_siz, req_ben, req_wdt,
    output rdy, rsp_rdt, rsp_sts
  );

endinterface

// File: rtl/tcb_lib_chunk_sel.sv
// Picks the next chunk from a byte mask: b is the lowest enabled lane, k the
// log2 size of the largest naturally aligned, fully enabled block at b.
module tcb_lib_chunk_sel #(
  parameter  int unsigned BEN = 4,
  localparam int unsigned BW  = $clog2(BEN),
  localparam int unsigned SW  = $clog2(BW + 1)
) (
  input  logic [BEN-1:0] mask,
  output logic [BW-1:0]  b,
  output logic [SW-1:0]  k
);

  logic [BEN-1:0] w_shr;
  logic [BEN-1:0] w_ones;
  logic           w_found;

  // Lowest set bit, then grow the chunk while it stays aligned and fully set.
  // An empty mask yields b=0, k=0; callers gate on mask!=0.
  always_comb begin
    b       = '0;
    k       = '0;
    w_found = 1'b0;
    w_shr   = '0;
    w_ones  = '0;
    for (int i = 0; i < int'(BEN); i++) begin
      if (!w_found && mask[i]) begin
        b       = BW'(i);
        w_found = 1'b1;
      end
    end
    w_shr = mask >> b;
    for (int kk = 1; kk <= int'(BW); kk++) begin
      w_ones = BEN'((64'd1 << (1 << kk)) - 64'd1);
      if (((int'(b) % (1 << kk)) == 0) && ((w_shr & w_ones) == w_ones)) begin
        k = SW'(kk);
      end
    end
  end

endmodule

// File: rtl/tcb_lib_memory2reference.sv
// Splits one byte-enable (memory mode) transfer into an ordered sequence of
// size-encoded (reference mode) transfers, one per aligned power-of-two chunk.
// Single-chunk transfers pass straight through without touching the FSM.
module tcb_lib_memory2reference
  import tcb_pkg::*;
#(
  parameter bit CHK = 1'b1
) (
  input logic clk,
  input logic rst_n,
  tcb_if.sub  sub,
  tcb_if.man  man
);

  localparam int unsigned DAT = sub.DAT;
  localparam int unsigned ADR = sub.ADR;
  localparam int unsigned BEN = DAT / 8;
  localparam int unsigned LBN = $clog2(BEN);
  localparam int unsigned SIZ = tcb_siz_w(DAT);

  generate
    if (CHK) begin : g_chk
      if (sub.MOD != TCB_MEMORY) begin : g_sub_mod
        $error("sub port must be in MEMORY mode");
      end
      if (man.MOD != TCB_REFERENCE) begin : g_man_mod
        $error("man port must be in REFERENCE mode");
      end
      if ((sub.DAT != man.DAT) || (sub.ADR != man.ADR)) begin : g_width
        $error("sub and man DAT/ADR widths differ");
      end
      if ((sub.DLY != 0) || (man.DLY != 0)) begin : g_dly
        $error("both ports must have DLY=0");
      end
      if (sub.ORD != TCB_DESCENDING) begin : g_ord
        $error("sub port must use DESCENDING byte order");
      end
    end
  endgenerate

  tcb_m2r_state_t r_state;
  logic [BEN-1:0] r_mask;
  logic [DAT-1:0] r_rdt;
  logic           r_sts;

  logic [BEN-1:0] w_mask;
  logic [BEN-1:0] w_chunk;
  logic [BEN-1:0] w_rem;
  logic [LBN-1:0] w_b;
  logic [SIZ-1:0] w_k;
  logic           w_act;
  logic           w_final;
  logic           w_hs;
  logic [DAT-1:0] w_wdt;
  logic [DAT-1:0] w_rdt_cur;
  int             w_lane;

  assign w_mask  = (r_state == M2R_IDLE) ? sub.req_ben : r_mask;
  assign w_act   = |w_mask;
  assign w_rem   = w_mask & ~w_chunk;
  assign w_final = ~|w_rem;
  assign w_hs    = man.vld & man.rdy;

  tcb_lib_chunk_sel #(
    .BEN (BEN)
  ) u_chunk_sel (
    .mask (w_mask),
    .b    (w_b),
    .k    (w_k)
  );

  // Lanes covered by the current chunk; empty when there is nothing to send.
  always_comb begin
    w_chunk = '0;
    for (int i = 0; i < int'(BEN); i++) begin
      if ((i >= int'(w_b)) && (i < int'(w_b) + (1 << w_k))) begin
        w_chunk[i] = w_act;
      end
    end
  end

  // Byte steering between sub lanes and LSB-aligned man lanes; the same
  // lane map serves write data out and read data back.
  always_comb begin
    w_wdt     = '0;
    w_rdt_cur = '0;
    w_lane    = 0;
    for (int j = 0; j < int'(BEN); j++) begin
      if (w_act && (j < (1 << w_k))) begin
        w_lane = sub.req_ndn ? (int'(w_b) + (1 << w_k) - 1 - j) : (int'(w_b) + j);
        w_wdt[8*j +: 8]          = sub.req_wdt[8*w_lane +: 8];
        w_rdt_cur[8*w_lane +: 8] = man.rsp_rdt[8*j +: 8];
      end
    end
  end

  assign man.vld     = sub.vld & w_act;
  assign man.req_cmd = sub.req_cmd;
  assign man.req_wen = sub.req_wen;
  assign man.req_ndn = sub.req_ndn;
  assign man.req_adr = {sub.req_adr[ADR-1:LBN], w_b};
  assign man.req_siz = w_k;
  assign man.req_ben = '1;
  assign man.req_wdt = w_wdt;

  // An empty mask completes on its own; otherwise only the last chunk
  // releases the sub request.
  assign sub.rdy     = w_act ? (w_final & man.rdy) : 1'b1;
  assign sub.rsp_rdt = r_rdt | w_rdt_cur;
  assign sub.rsp_sts = r_sts | (w_act & man.rsp_sts);

  // Sequencer: remembers the leftover mask and accumulates response data
  // across chunks; clears everything on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= M2R_IDLE;
      r_mask  <= '0;
      r_rdt   <= '0;
      r_sts   <= 1'b0;
    end else begin
      case (r_state)
        M2R_IDLE: begin
          if (w_hs && !w_final) begin
            r_state <= M2R_BUSY;
            r_mask  <= w_rem;
            r_rdt   <= w_rdt_cur;
            r_sts   <= man.rsp_sts;
          end
        end
        M2R_BUSY: begin
          if (w_hs) begin
            if (w_final) begin
              r_state <= M2R_IDLE;
              r_mask  <= '0;
              r_rdt   <= '0;
              r_sts   <= 1'b0;
            end else begin
              r_mask  <= w_rem;
              r_rdt   <= r_rdt | w_rdt_cur;
              r_sts   <= r_sts | man.rsp_sts;
            end
          end
        end
        default: begin
          r_state <= M2R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcb_lib_memory2reference.sv
// Bench for the memory-to-reference converter: directed cases with literal
// expectations plus randomized transfers against a chunk-list model.
module tb_tcb_lib_memory2reference;
  import tcb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  tcb_if #(.MOD(TCB_MEMORY),    .ORD(TCB_DESCENDING), .DLY(0), .DAT(32), .ADR(32)) u_sub ();
  tcb_if #(.MOD(TCB_REFERENCE), .ORD(TCB_DESCENDING), .DLY(0), .DAT(32), .ADR(32)) u_man ();

  tcb_lib_memory2reference #(
    .CHK (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (u_sub),
    .man   (u_man)
  );

  int checks = 0;
  int errors = 0;

  // model: chunk list for the current request
  int          m_n;
  logic [31:0] m_adr [4];
  int          m_siz [4];
  int          m_b   [4];
  int          m_sz  [4];
  logic [31:0] m_wdt [4];

  // fixed man responses for directed cases
  logic [31:0] fix_rdt [4];
  logic        fix_sts [4];

  // values observed from the DUT at handshakes
  int          d_n;
  logic [31:0] d_adr [4];
  logic [1:0]  d_siz [4];
  logic [31:0] d_rdt;
  logic        d_sts;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_plan(input logic [31:0] adr, input logic [3:0] ben,
                                     input logic ndn, input logic [31:0] wdt);
    logic [3:0]  rem;
    logic [31:0] w;
    int          b, k, sz, src;
    bit          ok;
    rem = ben;
    m_n = 0;
    while (rem != 4'b0000) begin
      b = 0;
      while (!rem[b]) b++;
      k = 0;
      for (int kk = 1; kk <= 2; kk++) begin
        sz = 1 << kk;
        ok = ((b % sz) == 0) && (b + sz <= 4);
        if (ok) for (int i = b; i < b + sz; i++) if (!rem[i]) ok = 0;
        if (ok) k = kk;
      end
      sz = 1 << k;
      w  = '0;
      for (int j = 0; j < sz; j++) begin
        src = ndn ? (b + sz - 1 - j) : (b + j);
        w[8*j +: 8] = wdt[8*src +: 8];
      end
      m_adr[m_n] = (adr & 32'hFFFF_FFFC) | 32'(b);
      m_siz[m_n] = k;
      m_b[m_n]   = b;
      m_sz[m_n]  = sz;
      m_wdt[m_n] = w;
      for (int i = b; i < b + sz; i++) rem[i] = 1'b0;
      m_n++;
    end
  endfunction

  function automatic logic [31:0] map_rdt(input int b, input int sz, input logic ndn,
                                          input logic [31:0] r);
    logic [31:0] o;
    int          dst;
    o = '0;
    for (int j = 0; j < sz; j++) begin
      dst = ndn ? (b + sz - 1 - j) : (b + j);
      o[8*dst +: 8] = r[8*j +: 8];
    end
    return o;
  endfunction

  // one sub transfer; rnd selects random stalls/responses, else the fixed
  // tables with a stall of stall_n cycles on chunk stall_idx
  task automatic xfer(input logic wen, input logic ndn, input logic [31:0] adr,
                      input logic [3:0] ben, input logic [31:0] wdt,
                      input bit rnd, input int stall_idx, input int stall_n);
    logic [31:0] acc;
    logic        sts_acc;
    logic [31:0] rdt;
    logic        sts;
    int          nst;
    bit          last;
    model_plan(adr, ben, ndn, wdt);
    u_sub.vld     = 1'b1;
    u_sub.req_cmd = wen;
    u_sub.req_wen = wen;
    u_sub.req_ndn = ndn;
    u_sub.req_adr = adr;
    u_sub.req_ben = ben;
    u_sub.req_wdt = wdt;
    acc     = '0;
    sts_acc = 1'b0;
    d_n     = 0;
    d_rdt   = '0;
    d_sts   = 1'b0;
    if (m_n == 0) begin
      u_man.rdy     = 1'($urandom_range(0, 1));
      u_man.rsp_rdt = $urandom;
      u_man.rsp_sts = 1'b1;
      @(negedge clk);
      chk("empty_sub_rdy", u_sub.rdy, 1'b1);
      chk("empty_man_vld", u_man.vld, 1'b0);
      chk("empty_rdt", u_sub.rsp_rdt, 32'h0);
      chk("empty_sts", u_sub.rsp_sts, 1'b0);
      @(posedge clk); #1;
    end
    for (int ci = 0; ci < m_n; ci++) begin
      nst  = rnd ? int'($urandom_range(0, 2)) : ((ci == stall_idx) ? stall_n : 0);
      last = (ci == m_n - 1);
      for (int s = 0; s <= nst; s++) begin
        rdt = rnd ? $urandom : fix_rdt[ci];
        sts = rnd ? ($urandom_range(0, 3) == 0) : fix_sts[ci];
        u_man.rdy     = (s == nst);
        u_man.rsp_rdt = rdt;
        u_man.rsp_sts = sts;
        @(negedge clk);
        chk("man_vld", u_man.vld, 1'b1);
        chk("man_adr", u_man.req_adr, m_adr[ci]);
        chk("man_siz", u_man.req_siz, m_siz[ci]);
        chk("man_wdt", u_man.req_wdt, m_wdt[ci]);
        chk("man_ben", u_man.req_ben, 4'hF);
        chk("man_wen_ndn", {u_man.req_cmd, u_man.req_wen, u_man.req_ndn}, {wen, wen, ndn});
        chk("sub_rdy", u_sub.rdy, (s == nst) && last);
        if (s == nst) begin
          acc     = acc | map_rdt(m_b[ci], m_sz[ci], ndn, rdt);
          sts_acc = sts_acc | sts;
          d_adr[d_n] = u_man.req_adr;
          d_siz[d_n] = u_man.req_siz;
          d_n++;
          if (last) begin
            chk("sub_rdt", u_sub.rsp_rdt, acc);
            chk("sub_sts", u_sub.rsp_sts, sts_acc);
            d_rdt = u_sub.rsp_rdt;
            d_sts = u_sub.rsp_sts;
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle_cycle();
    u_sub.vld     = 1'b0;
    u_sub.req_ben = 4'($urandom);
    u_man.rdy     = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_man_vld", u_man.vld, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    u_sub.vld     = 1'b0;
    u_sub.req_cmd = 1'b0;
    u_sub.req_wen = 1'b0;
    u_sub.req_ndn = 1'b0;
    u_sub.req_adr = '0;
    u_sub.req_siz = '0;
    u_sub.req_ben = '0;
    u_sub.req_wdt = '0;
    u_man.rdy     = 1'b0;
    u_man.rsp_rdt = 32'hDEAD_BEEF;
    u_man.rsp_sts = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fix_rdt[i] = '0;
      fix_sts[i] = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_man_vld", u_man.vld, 1'b0);
    chk("reset_rdt", u_sub.rsp_rdt, 32'h0);
    chk("reset_sts", u_sub.rsp_sts, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full word write passes straight through
    xfer(1'b1, 1'b0, 32'h100, 4'b1111, 32'hA1B2_C3D4, 1'b0, -1, 0);
    chk("w1111_model_n", m_n, 1);
    chk("w1111_adr", d_adr[0], 32'h100);
    chk("w1111_siz", d_siz[0], 2'd2);

    // two single-byte reads, result assembled from both
    fix_rdt[0] = 32'h0000_0011;
    fix_rdt[1] = 32'h0000_0033;
    xfer(1'b0, 1'b0, 32'h200, 4'b0101, 32'h0, 1'b0, -1, 0);
    chk("r0101_adr0", d_adr[0], 32'h200);
    chk("r0101_adr1", d_adr[1], 32'h202);
    chk("r0101_siz", {d_siz[0], d_siz[1]}, 4'b0000);
    chk("r0101_rdt", d_rdt, 32'h0033_0011);

    xfer(1'b1, 1'b0, 32'h200, 4'b1110, 32'h4433_2211, 1'b0, -1, 0);
    chk("b1110_model_n", m_n, 2);
    chk("b1110_adr0", d_adr[0], 32'h201);
    chk("b1110_siz0", d_siz[0], 2'd0);
    chk("b1110_adr1", d_adr[1], 32'h202);
    chk("b1110_siz1", d_siz[1], 2'd1);
    chk("b1110_model_wdt1", m_wdt[1], 32'h0000_4433);

    xfer(1'b1, 1'b0, 32'h200, 4'b0110, 32'h4433_2211, 1'b0, -1, 0);
    chk("b0110_adr0", d_adr[0], 32'h201);
    chk("b0110_adr1", d_adr[1], 32'h202);
    chk("b0110_siz", {d_siz[0], d_siz[1]}, 4'b0000);

    // stall on the second chunk, error status only on the first
    fix_rdt[0] = 32'h0000_00AA;
    fix_rdt[1] = 32'h0000_00BB;
    fix_sts[0] = 1'b1;
    fix_sts[1] = 1'b0;
    xfer(1'b0, 1'b0, 32'h300, 4'b0101, 32'h0, 1'b0, 1, 3);
    chk("stall_sts", d_sts, 1'b1);
    chk("stall_rdt", d_rdt, 32'h00BB_00AA);
    fix_sts[0] = 1'b0;
    idle_cycle();

    // big-endian word: lanes reversed on the man side
    fix_rdt[0] = 32'h0102_0304;
    xfer(1'b1, 1'b1, 32'h400, 4'b1111, 32'h1122_3344, 1'b0, -1, 0);
    chk("be_model_wdt", m_wdt[0], 32'h4433_2211);
    chk("be_rdt", d_rdt, 32'h0403_0201);

    // reset in the middle of a two-chunk read
    u_sub.vld     = 1'b1;
    u_sub.req_cmd = 1'b0;
    u_sub.req_wen = 1'b0;
    u_sub.req_ndn = 1'b0;
    u_sub.req_adr = 32'h500;
    u_sub.req_ben = 4'b0101;
    u_man.rdy     = 1'b1;
    u_man.rsp_rdt = 32'h0000_0055;
    u_man.rsp_sts = 1'b1;
    @(negedge clk);
    chk("rst_chunk0_adr", u_man.req_adr, 32'h500);
    @(posedge clk); #1;
    chk("rst_busy_adr", u_man.req_adr, 32'h502);
    chk("rst_busy_vld", u_man.vld, 1'b1);
    rst_n         = 1'b0;
    u_sub.vld     = 1'b0;
    u_sub.req_ben = 4'b0000;
    #1;
    chk("rst_async_man_vld", u_man.vld, 1'b0);
    chk("rst_async_rdt", u_sub.rsp_rdt, 32'h0);
    chk("rst_async_sts", u_sub.rsp_sts, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fix_rdt[0] = 32'hCAFE_F00D;
    fix_sts[0] = 1'b0;
    xfer(1'b0, 1'b0, 32'h600, 4'b1111, 32'h0, 1'b0, -1, 0);
    chk("after_rst_n", d_n, 1);
    chk("after_rst_rdt", d_rdt, 32'hCAFE_F00D);
    xfer(1'b1, 1'b0, 32'h700, 4'b0000, 32'h1234_5678, 1'b0, -1, 0);

    // randomized transfers, some back-to-back
    for (int t = 0; t < 200; t++) begin
      xfer(1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom, 1'b1, -1, 0);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
